// File: rtl/alu_seq_if.sv
// Operation request / result bundle between a requester and the sequential ALU.
// The slave modport is the ALU side; the master modport is the requester side.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_res;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_res, o_carry, o_overflow, o_zero
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_res, o_carry, o_overflow, o_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Registered two's-complement ALU: single-cycle simple ops, WIDTH-iteration shift-add
// signed multiply. Result and flags hold between operations.
module alu_seq #(
    parameter int unsigned WIDTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StMul  = 2'd2;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpNot = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;
    localparam logic [2:0] OpLt  = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH:0]   mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    // Magnitudes need WIDTH+1 bits so the most-negative operand is representable.
    logic [WIDTH:0] a_ext, b_ext, a_mag, b_mag;
    assign a_ext = {bus.i_a[WIDTH-1], bus.i_a};
    assign b_ext = {bus.i_b[WIDTH-1], bus.i_b};
    assign a_mag = a_ext[WIDTH] ? (~a_ext + {{WIDTH{1'b0}}, 1'b1}) : a_ext;
    assign b_mag = b_ext[WIDTH] ? (~b_ext + {{WIDTH{1'b0}}, 1'b1}) : b_ext;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] simple_res;
    logic             simple_carry;
    logic             simple_ovf;

    always_comb begin
        b_eff        = (op_q == OpSub) ? ~b_q : b_q;
        sum          = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OpSub)};
        simple_res   = '0;
        simple_carry = 1'b0;
        simple_ovf   = 1'b0;
        case (op_q)
            OpAdd, OpSub: begin
                simple_res   = sum[WIDTH-1:0];
                simple_carry = sum[WIDTH];
                simple_ovf   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                               (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpNot:   simple_res = ~a_q;
            OpAnd:   simple_res = a_q & b_q;
            OpOr:    simple_res = a_q | b_q;
            OpXor:   simple_res = a_q ^ b_q;
            OpLt:    simple_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: simple_res = '0;
        endcase
    end

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;

    always_comb begin
        prod    = neg_q ? (~acc_q + {{(PW-1){1'b0}}, 1'b1}) : acc_q;
        mul_res = prod[WIDTH-1:0];
        // Out of range whenever the full product is not the sign-extended low half.
        mul_ovf = (prod != {{WIDTH{mul_res[WIDTH-1]}}, mul_res});
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    op_d = bus.i_op;
                    a_d  = bus.i_a;
                    b_d  = bus.i_b;
                    if (bus.i_op == OpMul) begin
                        state_d  = StMul;
                        mcand_d  = {{(PW-WIDTH-1){1'b0}}, a_mag};
                        mplier_d = b_mag;
                        acc_d    = '0;
                        neg_d    = bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
                        cnt_d    = '0;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                res_d   = simple_res;
                carry_d = simple_carry;
                ovf_d   = simple_ovf;
                zero_d  = (simple_res == '0);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    res_d   = mul_res;
                    carry_d = 1'b0;
                    ovf_d   = mul_ovf;
                    zero_d  = (mul_res == '0);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_busy     = (state_q != StIdle);
    assign bus.o_done     = done_q;
    assign bus.o_res      = res_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_zero     = zero_q;
endmodule
